// File: rtl/game_tick_ctrl.sv
// Snake-game step sequencer: level-dependent tick, then move/check/draw request-done handshake.
// Optional per-phase watchdog is enabled by defining TICK_WDOG_EN.
module game_tick_ctrl #(
  parameter int BASE_PERIOD = 50000000,
  parameter int STEP        = 5000000,
  parameter int MIN_PERIOD  = 10000000,
  parameter int CNT_W       = 27,
  parameter int WDOG_CYC    = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause_tgl,
  input  logic [3:0] level,
  output logic       move_req,
  input  logic       move_done,
  output logic       chk_req,
  input  logic       chk_done,
  input  logic       game_over,
  output logic       draw_req,
  input  logic       draw_done,
  output logic       running,
  output logic       paused,
  output logic [1:0] phase,
  output logic [7:0] miss_cnt,
  output logic       wdog_err
);

  typedef enum logic [2:0] {IDLE, WAIT_TICK, MOVE, CHECK, DRAW, OVER} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, period, period_new;
  logic signed [31:0] period_calc;
  logic               cnt_en, tick, in_phase, phase_done, launch, wdog_trip;

  always_comb begin
    period_calc = BASE_PERIOD - STEP * int'(level);
    period_new  = (period_calc < MIN_PERIOD) ? CNT_W'(MIN_PERIOD) : period_calc[CNT_W-1:0];
  end

  assign in_phase = (state == MOVE) || (state == CHECK) || (state == DRAW);
  assign launch   = ((state == IDLE) || (state == OVER)) && start;
  assign cnt_en   = running && !paused;
  assign tick     = cnt_en && (cnt == period - 1'b1);

  always_comb begin
    phase_done = 1'b0;
    case (state)
      MOVE:    phase_done = move_done;
      CHECK:   phase_done = chk_done;
      DRAW:    phase_done = draw_done;
      default: phase_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, OVER: if (start) state_nxt = WAIT_TICK;
      WAIT_TICK:  if (tick) state_nxt = MOVE;
      MOVE: begin
        if (wdog_trip)      state_nxt = OVER;
        else if (move_done) state_nxt = CHECK;
      end
      CHECK: begin
        if (wdog_trip)     state_nxt = OVER;
        else if (chk_done) state_nxt = game_over ? OVER : DRAW;
      end
      DRAW: begin
        if (wdog_trip)      state_nxt = OVER;
        else if (draw_done) state_nxt = WAIT_TICK;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    move_req = (state == MOVE);
    chk_req  = (state == CHECK);
    draw_req = (state == DRAW);
    running  = (state == WAIT_TICK) || in_phase;
    case (state)
      MOVE:    phase = 2'd1;
      CHECK:   phase = 2'd2;
      DRAW:    phase = 2'd3;
      default: phase = 2'd0;
    endcase
  end

  // Ticks keep their spacing during a step; a tick landing in a phase is only counted as an overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      period   <= '0;
      miss_cnt <= '0;
    end else if (launch) begin
      cnt      <= '0;
      period   <= period_new;
      miss_cnt <= '0;
    end else begin
      if (tick) begin
        cnt    <= '0;
        period <= period_new;
      end else if (cnt_en) begin
        cnt <= cnt + 1'b1;
      end
      if (tick && in_phase && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       paused <= 1'b0;
    else if (state_nxt == OVER)       paused <= 1'b0;
    else if (running && pause_tgl)    paused <= ~paused;
  end

`ifdef TICK_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC) + 1;

  logic [WDOG_W-1:0] wcnt;
  logic              wdog_flag;

  // A done on the limit cycle still wins over the watchdog.
  assign wdog_trip = in_phase && !phase_done && (wcnt == WDOG_W'(WDOG_CYC - 1));
  assign wdog_err  = wdog_flag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt      <= '0;
      wdog_flag <= 1'b0;
    end else begin
      if (state_nxt != state) wcnt <= '0;
      else if (in_phase)      wcnt <= wcnt + 1'b1;
      if (wdog_trip) wdog_flag <= 1'b1;
    end
  end
`else
  assign wdog_trip = 1'b0;
  assign wdog_err  = 1'b0;
`endif

endmodule
